seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
Programmable serial-pattern detection controller for the FSM sequence-detector family. It holds a run-time pattern of up to PW bits and a configurable length, selects overlapping or non-overlapping detection, and counts matches. It is sequenced through an IDLE/ARMED/DONE state machine with start/stop control and a match-count target. It replaces per-pattern hard-coded detectors (e.g. 101) with one configurable block driven by a host or test sequencer.

Parameters:
PW, 8, maximum pattern length in bits (>=2)
CW, 8, width of match counter and target

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cfg_we  input  1  configuration write strobe (honoured only in IDLE)
cfg_pattern  input  PW  pattern; bit [len-1] is first serial bit, bit [0] is last
cfg_len  input  $clog2(PW+1)  pattern length, legal 1..PW
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  input  CW  matches before DONE; 0 = unlimited
start  input  1  arm detector (IDLE or DONE)
stop  input  1  abort to IDLE
x_valid  input  1  serial bit qualifier
x  input  1  serial data bit
busy  output  1  high in ARMED
match  output  1  one-cycle match pulse
match_count  output  CW  matches since last start, saturating
done  output  1  high in DONE
cfg_err  output  1  sticky illegal-length flag

Behaviour:
- One clock, synchronous active-high reset: rst=1 at a rising edge forces the reset state on that edge, from any state, including mid-operation.
- Reset values: state=IDLE. Outputs busy=0, match=0, match_count=0, done=0, cfg_err=0. Internal registers: hist=0, fill=0. Config registers: pattern=...0101, len=3, overlap=0, target=0.
- States: IDLE, ARMED, DONE. busy=(ARMED), done=(DONE); both come from registered state.
- Configuration:
  - cfg_we in IDLE latches pattern, len, overlap and target.
  - If cfg_len is 0 or >PW, the config registers are not updated and cfg_err is set.
  - A later legal write clears cfg_err.
  - cfg_we in ARMED or DONE is ignored; no cfg_err change.
- Transitions:
  - IDLE -> ARMED on start when cfg_err=0. Start is ignored while cfg_err=1.
  - DONE -> ARMED on start.
  - ARMED or DONE -> IDLE on stop.
  - stop has priority over start in the same cycle.
  - Entering ARMED clears hist, fill and match_count.
  - Entering IDLE via stop retains match_count.
- Detection (ARMED only; x_valid=0 cycles hold all detection state):
  - On a cycle with x_valid=1: hist_n={hist[PW-2:0],x} and fill_n=min(fill+1,PW).
  - Hit when fill_n>=len and hist_n[len-1:0]==pattern[len-1:0].
  - On a hit: match=1 on the next cycle (registered, latency 1 from the sampling edge), and match_count increments in that same cycle, saturating at 2^CW-1.
  - Non-overlap mode: a hit loads fill=0, so the bits of the matched sequence cannot be reused.
  - Overlap mode: a hit leaves fill_n unchanged.
- Target:
  - If target!=0 and the incremented count equals target, the state moves to DONE in the same edge that raises match.
  - In DONE, match falls the next cycle, x is ignored, and count is held.
  - Target 0: no DONE; the block stays in ARMED until stop.
  - A stop on the same edge as a hit: stop wins, with no match pulse and no count increment.
- match is 0 in every cycle not immediately following a hit.
- x_valid outside ARMED has no effect.

Test Plan:
1. Reset defaults, non-overlap 101. Start, then bits 1,0,1,0,1 (x_valid=1 each cycle) -> single match pulse the cycle after bit 3; match_count=1; no pulse after bit 5.
2. Overlap 101. cfg_overlap=1, len=3, pattern=101, then bits 1,0,1,0,1 -> match after bits 3 and 5; match_count=2.
3. Target. pattern=11, len=2, overlap=1, target=3, bits 1,1,1,1,1 -> matches after bits 2,3,4; DONE with done=1 and busy=0 at the third pulse; bit 5 ignored; count=3. start -> ARMED with count=0.
4. Config error. cfg_we with cfg_len=0 -> cfg_err=1, config unchanged, start ignored (busy stays 0). cfg_len=4, pattern=1001 -> cfg_err=0. Bits 1,0,0,1 -> match, count=1.
5. Gapped valid and stop. Bits 1,0,1 with x_valid low between each -> one match. Then stop asserted together with start and with the completing bit of a second 101 -> IDLE, no match pulse, count held at 1.
6. Reset mid-run. Assert rst in ARMED after bits 1,0 -> next cycle all outputs 0 and state IDLE. start, then bit 1 alone -> no match (history cleared).

Source files
------------

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Purpose  : Programmable serial-pattern detector with IDLE/ARMED/DONE
//            sequencing, overlap select and a saturating match counter.
// Revision : 1.0  initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [PW-1:0]             cfg_pattern,
    input  logic [$clog2(PW+1)-1:0]   cfg_len,
    input  logic                      cfg_overlap,
    input  logic [CW-1:0]             cfg_target,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      x_valid,
    input  logic                      x,
    output logic                      busy,
    output logic                      match,
    output logic [CW-1:0]             match_count,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int LW = $clog2(PW+1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [LW-1:0] c_PW_LEN      = LW'(PW);
    localparam logic [PW-1:0] c_RST_PATTERN = PW'(5);
    localparam logic [LW-1:0] c_RST_LEN     = LW'(3);
    localparam logic [CW-1:0] c_CNT_MAX     = '1;

    logic [1:0]    r_state;
    // Only PW-1 bits are kept; the newest bit is appended combinationally.
    logic [PW-2:0] r_hist;
    logic [LW-1:0] r_fill;
    logic          r_match;
    logic [CW-1:0] r_count;
    logic          r_cfg_err;
    logic [PW-1:0] r_pattern;
    logic [LW-1:0] r_len;
    logic          r_overlap;
    logic [CW-1:0] r_target;

    logic [PW-1:0] w_hist_n;
    logic [LW-1:0] w_fill_inc;
    logic [PW-1:0] w_mask;
    logic          w_armed;
    logic          w_hit;
    logic [CW-1:0] w_count_inc;
    logic          w_reach;
    logic          w_cfg_legal;

    assign w_armed     = (r_state == c_ARMED);
    assign w_hist_n    = {r_hist, x};
    assign w_fill_inc  = (r_fill >= c_PW_LEN) ? c_PW_LEN : r_fill + LW'(1);
    assign w_count_inc = (r_count == c_CNT_MAX) ? r_count : r_count + CW'(1);
    assign w_reach     = (r_target != '0) && (w_count_inc == r_target);
    assign w_cfg_legal = (cfg_len != '0) && (cfg_len <= c_PW_LEN);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PW; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    // A stop in the same cycle suppresses the hit entirely.
    assign w_hit = w_armed && x_valid && !stop
                && (w_fill_inc >= r_len)
                && (((w_hist_n ^ r_pattern) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_count   <= '0;
            r_cfg_err <= 1'b0;
            r_pattern <= c_RST_PATTERN;
            r_len     <= c_RST_LEN;
            r_overlap <= 1'b0;
            r_target  <= '0;
        end else begin
            r_match <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (cfg_we) begin
                        if (w_cfg_legal) begin
                            r_pattern <= cfg_pattern;
                            r_len     <= cfg_len;
                            r_overlap <= cfg_overlap;
                            r_target  <= cfg_target;
                            r_cfg_err <= 1'b0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                    if (start && !stop && !r_cfg_err) begin
                        r_state <= c_ARMED;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_count <= '0;
                    end
                end
                c_ARMED: begin
                    if (stop) begin
                        r_state <= c_IDLE;
                    end else if (x_valid) begin
                        r_hist <= w_hist_n[PW-2:0];
                        if (w_hit) begin
                            r_match <= 1'b1;
                            r_count <= w_count_inc;
                            r_fill  <= r_overlap ? w_fill_inc : '0;
                            if (w_reach) begin
                                r_state <= c_DONE;
                            end
                        end else begin
                            r_fill <= w_fill_inc;
                        end
                    end
                end
                c_DONE: begin
                    if (stop) begin
                        r_state <= c_IDLE;
                    end else if (start) begin
                        r_state <= c_ARMED;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state == c_ARMED);
    assign done        = (r_state == c_DONE);
    assign match       = r_match;
    assign match_count = r_count;
    assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire
